// File: rtl/sad_accum_pipe.sv
// Two-stage sum-of-absolute-differences accumulator with a held output register.
// Stage 1 registers per-lane |a-b|, stage 2 accumulates, and the output register holds the block result.
module sad_accum_pipe #(
    parameter int W     = 2,
    parameter int LANES = 2,
    parameter int BLOCK = 4,
    parameter int OW    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic                 in_last,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_sad,
    output logic                 out_ovf
);
    localparam int AW = $clog2(LANES * BLOCK * ((1 << W) - 1) + 1);
    localparam int CW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int XW = ((AW > OW) ? AW : OW) + 1;

    // valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds its data stable while valid=1 and ready=0.
    logic stall;
    logic accept;
    logic blk_end;

    logic [CW-1:0]        cnt;
    logic                 s1_valid;
    logic                 s1_end;
    logic                 s1_sat;
    logic [LANES*W-1:0]   s1_diff;
    logic [LANES*W-1:0]   diff_c;
    logic [AW-1:0]        lane_sum;
    logic [AW-1:0]        acc;
    logic                 s2_valid;
    logic                 s2_sat;
    logic [AW-1:0]        s2_sum;
    logic [XW-1:0]        sum_x;
    logic                 ovf_c;
    logic [OW-1:0]        res_c;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign blk_end  = in_last | (cnt == CW'(BLOCK - 1));

    always_comb begin
        diff_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_a[i*W +: W] > in_b[i*W +: W])
                diff_c[i*W +: W] = in_a[i*W +: W] - in_b[i*W +: W];
            else
                diff_c[i*W +: W] = in_b[i*W +: W] - in_a[i*W +: W];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + AW'(s1_diff[i*W +: W]);
    end

    // Widen before comparing so the overflow test also works when AW <= OW.
    always_comb begin
        sum_x = XW'(s2_sum);
        ovf_c = (sum_x > XW'({OW{1'b1}}));
        res_c = sum_x[OW-1:0];
        if (ovf_c && s2_sat)
            res_c = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_end   <= 1'b0;
            s1_sat   <= 1'b0;
            s1_diff  <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= diff_c;
                s1_end  <= blk_end;
                s1_sat  <= sat_en;
                cnt     <= blk_end ? '0 : cnt + CW'(1);
            end
        end
    end

    // The closing beat hands the final sum to stage 2 and clears the accumulator in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid & s1_end;
            if (s1_valid) begin
                if (s1_end) begin
                    acc    <= '0;
                    s2_sum <= acc + lane_sum;
                    s2_sat <= s1_sat;
                end else begin
                    acc <= acc + lane_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_sad <= res_c;
                out_ovf <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_sad_accum_pipe.sv
// Bench for sad_accum_pipe: default build (OW=5) and an OW=4 build driven in lockstep,
// checked against a queue of expected {ovf5, sad5, ovf4, sad4} results.
module tb_sad_accum_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_last;
    logic       sat_en;
    logic       out_ready;
    logic       in_ready, in_ready4;
    logic       out_valid, out_valid4;
    logic [4:0] out_sad;
    logic [3:0] out_sad4;
    logic       out_ovf, out_ovf4;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];
    int m_sum = 0;
    int m_cnt = 0;
    logic rand_on;

    always #5 clk = ~clk;

    sad_accum_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad), .out_ovf(out_ovf)
    );

    sad_accum_pipe #(.OW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .sat_en(sat_en),
        .out_valid(out_valid4), .out_ready(out_ready), .out_sad(out_sad4), .out_ovf(out_ovf4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          nb;
        logic        sat;
        logic [4:0]  sad5;
        logic        ovf5;
        logic [3:0]  sad4;
        logic        ovf4;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beat_sum(input logic [3:0] a, input logic [3:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 2; i++) begin
            int x, y;
            x = int'(a[i*2 +: 2]);
            y = int'(b[i*2 +: 2]);
            s += (x > y) ? (x - y) : (y - x);
        end
        return s;
    endfunction

    function automatic logic [10:0] mk_exp(input int s, input logic sat);
        logic       o5, o4;
        logic [4:0] s5;
        logic [3:0] s4;
        o5 = (s > 31);
        s5 = 5'(s);
        o4 = (s > 15);
        s4 = (o4 && sat) ? 4'd15 : 4'(s);
        return {o5, s5, o4, s4};
    endfunction

    // Drives one beat, waits for acceptance, and updates the block model.
    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic last,
                             input logic sat, input logic use_model);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_a = a; in_b = b; in_last = last; sat_en = sat; in_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                n++;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else begin
            m_sum += beat_sum(a, b);
            m_cnt++;
            if (last || m_cnt == 4) begin
                if (use_model)
                    exp_q.push_back(mk_exp(m_sum, sat));
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("out_ovf", out_ovf, e[10]);
                check("out_sad", out_sad, e[9:5]);
                check("out_valid4", out_valid4, 1);
                check("out_ovf4", out_ovf4, e[4]);
                check("out_sad4", out_sad4, e[3:0]);
            end
        end
    end

    initial begin
        int cyc;
        int nbeats;
        tbl[0] = '{16'hFFFF, 16'h0000, 4, 1'b0, 5'd24, 1'b0, 4'd8,  1'b1};
        tbl[1] = '{16'hFFFF, 16'h0000, 4, 1'b1, 5'd24, 1'b0, 4'd15, 1'b1};
        tbl[2] = '{16'h00CD, 16'h00F6, 2, 1'b0, 5'd6,  1'b0, 4'd6,  1'b0};
        tbl[3] = '{16'h0003, 16'h0000, 1, 1'b0, 5'd3,  1'b0, 4'd3,  1'b0};
        tbl[4] = '{16'h0000, 16'hFFFF, 4, 1'b1, 5'd24, 1'b0, 4'd15, 1'b1};
        tbl[5] = '{16'h9999, 16'h6666, 4, 1'b0, 5'd8,  1'b0, 4'd8,  1'b0};
        tbl[6] = '{16'h03FF, 16'h0000, 4, 1'b1, 5'd15, 1'b0, 4'd15, 1'b0};
        tbl[7] = '{16'h13FF, 16'h0000, 4, 1'b0, 5'd16, 1'b0, 4'd0,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_last = 1'b0; sat_en = 1'b0; out_ready = 1'b1; rand_on = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sad", out_sad, 0);
        check("rst_out_ovf", out_ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // First-result latency: out_valid two edges after the closing beat.
        for (int j = 0; j < 4; j++) send_beat(4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 2);
        drain();

        for (int k = 0; k < 8; k++) begin
            vec_t v;
            v = tbl[k];
            for (int j = 0; j < v.nb; j++)
                send_beat(v.a[j*4 +: 4], v.b[j*4 +: 4], (j == v.nb - 1) && (v.nb < 4),
                          v.sat, 1'b0);
            exp_q.push_back({v.ovf5, v.sad5, v.ovf4, v.sad4});
        end
        drain();

        // Back-pressure: hold result 1, stream block 2, then release.
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send_beat(4'h5, 4'h5, 1'b0, 1'b0, 1'b1);
        fork
            begin
                for (int j = 0; j < 4; j++) send_beat(4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_out_valid", out_valid, 1);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold_sad", out_sad, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset in the middle of a block.
        for (int j = 0; j < 4; j++) send_beat(4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
        drain();
        send_beat(4'h5, 4'h0, 1'b0, 1'b0, 1'b1);
        send_beat(4'h5, 4'h0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_sad", out_sad, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_ovf", out_ovf, 0);
        check("async_rst_in_ready", in_ready, 1);
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) send_beat(4'h5, 4'h0, 1'b0, 1'b0, 1'b1);
        drain();

        // Random beats, bubbles and consumer stalls.
        rand_on = 1'b1;
        fork
            begin
                for (int j = 0; j < 80; j++) begin
                    send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b1);
                    nbeats = $urandom_range(0, 2);
                    repeat (nbeats) begin
                        @(posedge clk); #1;
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        send_beat(4'hA, 4'h3, 1'b1, 1'b1, 1'b1);
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
